fasta_base_streamer: RTL and testbench
======================================

// Module: fasta_base_streamer
// PURPOSE
//  Hardware source side of the sw_gen_affine base interface. Parses an ASCII FASTA byte
//  stream. Record 1 is packed into the query bitstream and its length. Every later record is
//  streamed one 2-bit base per cycle on o_vld/o_data. A one-cycle o_clr pulse between
//  records drives the aligner's reset input, so the aligner scores each record independently.
// PARAMETERS
//  MAX_QUERY_LEN  50   max query bases packed into o_query
//  LEN_W          7    width of o_query_length (>= clog2(MAX_QUERY_LEN))
//  CNT_W          16   width of o_seq_cnt
// PORTS
//  clk             in   1                clock; all logic on rising edge
//  rst             in   1                reset, asynchronous, active-low
//  i_byte_vld      in   1                ASCII byte valid
//  i_byte          in   8                ASCII character
//  o_byte_rdy      out  1                byte accepted when i_byte_vld & o_byte_rdy
//  o_query         out  [0:2*MAX_QUERY_LEN-1]  packed query; base k on bits [2k:2k+1]
//  o_query_length  out  LEN_W            query base count minus 1 (aligner convention)
//  o_query_vld     out  1                query complete; held until rst
//  o_vld           out  1                o_data holds a database base
//  o_data          out  2                base code A=00 G=01 T=10 C=11
//  o_clr           out  1                1-cycle record-boundary pulse to the aligner reset
//  o_seq_cnt       out  CNT_W            count of completed database records; wraps
//  o_err           out  1                sticky: illegal character or query overflow
// BEHAVIOUR
//  Reset (rst=0, async): state=Q_WAIT; every output 0 except o_byte_rdy=1; o_query cleared.
//  An accepted byte is "acc". All outputs are registered. o_vld/o_data follow acc by 1 cycle.
//  Character classes:
//   - base: ACGT/acgt
//   - LF: 8'h0A
//   - CR: 8'h0D, ignored in every state
//   - hdr: '>'
//   - other: anything else
//  FSM:
//   - Q_WAIT: hdr -> Q_HDR. LF is ignored. Other chars set o_err and stay.
//   - Q_HDR: discard bytes until LF -> Q_SEQ.
//   - Q_SEQ:
//     - base: pack at index qcnt; qcnt++.
//     - base with qcnt==MAX_QUERY_LEN: drop it; set o_err.
//     - LF with qcnt>0: o_query_length=qcnt-1; o_query_vld=1 -> DB_WAIT.
//     - LF with qcnt==0: stay.
//     - other: set o_err; drop.
//   - DB_WAIT: hdr -> DB_HDR. base -> DB_SEQ and emit it. LF is ignored (blank line).
//   - DB_HDR: discard until LF -> DB_SEQ.
//   - DB_SEQ:
//     - base: emit (o_vld=1 next cycle).
//     - LF after >=1 base emitted: -> CLR.
//     - LF with no base yet: ignored.
//     - hdr: treated as end of record; -> CLR, then DB_HDR.
//     - other: set o_err; drop; no o_vld bubble fill.
//   - CLR: o_clr=1 for exactly 1 cycle; o_byte_rdy=0 that cycle; o_seq_cnt++ -> DB_WAIT
//     (or DB_HDR if entered via hdr).
//  o_byte_rdy is 1 in all states except CLR. The aligner has no backpressure.
//  o_vld and o_clr are never high in the same cycle. o_clr follows the last o_vld by >=1 cycle.
//  o_seq_cnt wraps from 2^CNT_W-1 to 0 silently.
//  A final record without a trailing LF is not terminated; streams must end with LF.
//  Reset mid-record aborts immediately. No o_clr is issued. The query must be resent.
// STRUCTURE
//  Package sw_pkg:
//   - base_t: 2-bit enum A/G/T/C
//   - ASCII_LF, ASCII_CR, ASCII_GT constants
//   - function ascii_to_base(input [7:0]) returning {is_base, base_t}
//   - state enum
//  Sub-module fasta_char_class: combinational classifier, byte -> {base, lf, cr, hdr, other},
//  shared with future parsers. Everything else lives in one always_ff plus next-state logic.
// TESTING
//  1. ">q\nACGT\n>d1\nTTGA\n" -> o_query[0:7]=8'b00_11_01_10, o_query_length=3, o_query_vld=1.
//     o_data=10,10,01,00 on 4 consecutive o_vld cycles. o_clr 1 cycle after, o_seq_cnt=1.
//  2. 55-base query line -> first 50 bases packed, o_query_length=49, o_err=1,
//     DB streaming still works.
//  3. Two records back-to-back plus a blank line between them -> exactly 2 o_clr pulses,
//     o_seq_cnt=2. o_byte_rdy low only in the 2 CLR cycles.
//  4. "AcNgT\r\n" in DB_SEQ -> o_data 00,11,01,10; N drops with o_err=1; CR ignored.
//  5. Assert rst=0 mid-DB_SEQ with o_vld=1 -> all outputs 0 asynchronously.
//     After release, a fresh query is required (o_query_vld=0).
//  6. Held i_byte_vld with gaps (vld toggling) -> output base order unchanged.
//     o_vld only in cycles after an accepted base.

Source files
------------

// File: rtl/sw_pkg.sv
// rtl/sw_pkg.sv - shared types, ASCII constants and base decode for FASTA parsing
package sw_pkg;

  typedef enum logic [1:0] {
    BASE_A = 2'b00,
    BASE_G = 2'b01,
    BASE_T = 2'b10,
    BASE_C = 2'b11
  } base_t;

  typedef enum logic [2:0] {
    Q_WAIT,
    Q_HDR,
    Q_SEQ,
    DB_WAIT,
    DB_HDR,
    DB_SEQ,
    CLR
  } state_t;

  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_GT = 8'h3E;

  // Returns {is_base, code}; code is don't-care when is_base is 0.
  function automatic logic [2:0] ascii_to_base(input logic [7:0] c);
    case (c)
      8'h41, 8'h61: return {1'b1, BASE_A};
      8'h47, 8'h67: return {1'b1, BASE_G};
      8'h54, 8'h74: return {1'b1, BASE_T};
      8'h43, 8'h63: return {1'b1, BASE_C};
      default:      return {1'b0, BASE_A};
    endcase
  endfunction

endpackage

// File: rtl/fasta_char_class.sv
// rtl/fasta_char_class.sv - combinational FASTA byte classifier
module fasta_char_class
  import sw_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic       o_base,
  output base_t      o_code,
  output logic       o_lf,
  output logic       o_cr,
  output logic       o_hdr,
  output logic       o_other
);

  logic [2:0] dec;

  assign dec     = ascii_to_base(i_byte);
  assign o_base  = dec[2];
  assign o_code  = base_t'(dec[1:0]);
  assign o_lf    = (i_byte == ASCII_LF);
  assign o_cr    = (i_byte == ASCII_CR);
  assign o_hdr   = (i_byte == ASCII_GT);
  assign o_other = !(o_base || o_lf || o_cr || o_hdr);

endmodule

// File: rtl/fasta_base_streamer.sv
// rtl/fasta_base_streamer.sv - FASTA parser: packs the first record as query, streams the rest
module fasta_base_streamer
  import sw_pkg::*;
#(
  parameter int MAX_QUERY_LEN = 50,
  parameter int LEN_W         = 7,
  parameter int CNT_W         = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_byte_vld,
  input  logic [7:0]                   i_byte,
  output logic                         o_byte_rdy,
  output logic [0:2*MAX_QUERY_LEN-1]   o_query,
  output logic [LEN_W-1:0]             o_query_length,
  output logic                         o_query_vld,
  output logic                         o_vld,
  output logic [1:0]                   o_data,
  output logic                         o_clr,
  output logic [CNT_W-1:0]             o_seq_cnt,
  output logic                         o_err
);

  state_t           state, state_nx;
  logic [LEN_W-1:0] qcnt;
  logic             emitted, emitted_nx;
  logic             clr_to_hdr, clr_to_hdr_nx;
  logic             acc, pack, emit, err_set, qdone;
  logic             c_base, c_lf, c_cr, c_hdr, c_other;
  base_t            c_code;

  fasta_char_class u_class (
    .i_byte  (i_byte),
    .o_base  (c_base),
    .o_code  (c_code),
    .o_lf    (c_lf),
    .o_cr    (c_cr),
    .o_hdr   (c_hdr),
    .o_other (c_other)
  );

  assign acc = i_byte_vld && o_byte_rdy;

  always_comb begin
    state_nx      = state;
    emitted_nx    = emitted;
    clr_to_hdr_nx = clr_to_hdr;
    pack          = 1'b0;
    emit          = 1'b0;
    err_set       = 1'b0;
    qdone         = 1'b0;
    if (state == CLR) begin
      state_nx = clr_to_hdr ? DB_HDR : DB_WAIT;
    end else if (acc && !c_cr) begin
      case (state)
        Q_WAIT: begin
          if (c_hdr)      state_nx = Q_HDR;
          else if (!c_lf) err_set  = 1'b1;
        end
        Q_HDR: if (c_lf) state_nx = Q_SEQ;
        Q_SEQ: begin
          if (c_base) begin
            if (qcnt == LEN_W'(MAX_QUERY_LEN)) err_set = 1'b1;
            else                               pack    = 1'b1;
          end else if (c_lf) begin
            if (qcnt != '0) begin
              qdone    = 1'b1;
              state_nx = DB_WAIT;
            end
          end else begin
            err_set = 1'b1;
          end
        end
        DB_WAIT: begin
          if (c_hdr) begin
            state_nx = DB_HDR;
          end else if (c_base) begin
            emit       = 1'b1;
            emitted_nx = 1'b1;
            state_nx   = DB_SEQ;
          end else if (c_other) begin
            err_set = 1'b1;
          end
        end
        DB_HDR: begin
          if (c_lf) begin
            state_nx   = DB_SEQ;
            emitted_nx = 1'b0;
          end
        end
        DB_SEQ: begin
          if (c_base) begin
            emit       = 1'b1;
            emitted_nx = 1'b1;
          end else if (c_lf) begin
            if (emitted) begin
              state_nx      = CLR;
              clr_to_hdr_nx = 1'b0;
            end
          end else if (c_hdr) begin
            // A new header closes the running record before its own header is skipped.
            state_nx      = CLR;
            clr_to_hdr_nx = 1'b1;
          end else if (c_other) begin
            err_set = 1'b1;
          end
        end
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= Q_WAIT;
      qcnt           <= '0;
      emitted        <= 1'b0;
      clr_to_hdr     <= 1'b0;
      o_byte_rdy     <= 1'b1;
      o_query        <= '0;
      o_query_length <= '0;
      o_query_vld    <= 1'b0;
      o_vld          <= 1'b0;
      o_data         <= '0;
      o_clr          <= 1'b0;
      o_seq_cnt      <= '0;
      o_err          <= 1'b0;
    end else begin
      state      <= state_nx;
      emitted    <= emitted_nx;
      clr_to_hdr <= clr_to_hdr_nx;
      o_byte_rdy <= (state_nx != CLR);
      o_clr      <= (state_nx == CLR);
      o_vld      <= emit;
      if (emit) o_data <= c_code;
      for (int k = 0; k < MAX_QUERY_LEN; k++) begin
        if (pack && qcnt == LEN_W'(k)) o_query[2*k +: 2] <= c_code;
      end
      if (pack) qcnt <= qcnt + LEN_W'(1);
      if (qdone) begin
        o_query_length <= qcnt - LEN_W'(1);
        o_query_vld    <= 1'b1;
      end
      // Count on entry so the count already includes the record during its clear pulse.
      if (state_nx == CLR && state != CLR) o_seq_cnt <= o_seq_cnt + CNT_W'(1);
      if (err_set) o_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fasta_base_streamer.sv
// tb/tb_fasta_base_streamer.sv - self-checking bench for fasta_base_streamer
module tb_fasta_base_streamer;

  logic         clk;
  logic         rst;
  logic         i_byte_vld;
  logic [7:0]   i_byte;
  logic         o_byte_rdy;
  logic [0:99]  o_query;
  logic [6:0]   o_query_length;
  logic         o_query_vld;
  logic         o_vld;
  logic [1:0]   o_data;
  logic         o_clr;
  logic [15:0]  o_seq_cnt;
  logic         o_err;

  fasta_base_streamer dut (
    .clk(clk), .rst(rst), .i_byte_vld(i_byte_vld), .i_byte(i_byte),
    .o_byte_rdy(o_byte_rdy), .o_query(o_query), .o_query_length(o_query_length),
    .o_query_vld(o_query_vld), .o_vld(o_vld), .o_data(o_data), .o_clr(o_clr),
    .o_seq_cnt(o_seq_cnt), .o_err(o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  string ev_s = "";
  int rdy_low = 0;
  int vld_bad = 0;
  int overlap = 0;
  bit p_acc = 0;
  byte p_byte = 0;

  byte stim[$];
  string m_ev;
  logic [0:99] m_q;
  int m_qlen, m_cnt;
  bit m_qvld, m_err;

  typedef struct {
    string stim;
    string q;
    int    qlen;
    bit    qvld;
    bit    err;
    int    cnt;
    string ev;
    int    rdylow;
  } vec_t;
  vec_t tbl[$];

  function automatic bit isb(byte c);
    return c inside {8'h41, 8'h61, 8'h43, 8'h63, 8'h47, 8'h67, 8'h54, 8'h74};
  endfunction

  function automatic logic [1:0] ch2code(byte c);
    case (c)
      8'h41, 8'h61: return 2'b00;
      8'h47, 8'h67: return 2'b01;
      8'h54, 8'h74: return 2'b10;
      default:      return 2'b11;
    endcase
  endfunction

  function automatic byte code2ch(logic [1:0] d);
    case (d)
      2'b00:   return 8'h41;
      2'b01:   return 8'h47;
      2'b10:   return 8'h54;
      default: return 8'h43;
    endcase
  endfunction

  function automatic logic [0:99] qbits_of(string q);
    logic [0:99] r;
    r = '0;
    for (int i = 0; i < q.len(); i++) r[2*i +: 2] = ch2code(q[i]);
    return r;
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_s(string nm, string act, string exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", nm, act, exp);
    end
  endtask

  task automatic push_str(string t);
    for (int i = 0; i < t.len(); i++) stim.push_back(t[i]);
  endtask

  // Whole-stream reference: expected event string ('|' = record clear) and final outputs.
  task automatic model();
    int ph, qn;
    bit any;
    byte c;
    m_ev = ""; m_q = '0; m_qlen = 0; m_qvld = 0; m_err = 0; m_cnt = 0;
    ph = 0; qn = 0; any = 0;
    foreach (stim[i]) begin
      c = stim[i];
      if (c == 8'h0D) continue;
      case (ph)
        0: if (c == 8'h3E) ph = 1; else if (c != 8'h0A) m_err = 1;
        1: if (c == 8'h0A) ph = 2;
        2: begin
          if (isb(c)) begin
            if (qn < 50) begin m_q[2*qn +: 2] = ch2code(c); qn++; end
            else m_err = 1;
          end else if (c == 8'h0A) begin
            if (qn > 0) begin m_qlen = qn - 1; m_qvld = 1; ph = 3; end
          end else m_err = 1;
        end
        3: begin
          if (c == 8'h3E) ph = 4;
          else if (isb(c)) begin
            m_ev = $sformatf("%s%c", m_ev, code2ch(ch2code(c))); any = 1; ph = 5;
          end else if (c != 8'h0A) m_err = 1;
        end
        4: if (c == 8'h0A) begin ph = 5; any = 0; end
        default: begin
          if (isb(c)) begin
            m_ev = $sformatf("%s%c", m_ev, code2ch(ch2code(c))); any = 1;
          end else if (c == 8'h0A) begin
            if (any) begin m_ev = {m_ev, "|"}; m_cnt++; ph = 3; end
          end else if (c == 8'h3E) begin
            m_ev = {m_ev, "|"}; m_cnt++; ph = 4;
          end else m_err = 1;
        end
      endcase
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (o_vld) begin
      ev_s = $sformatf("%s%c", ev_s, code2ch(o_data));
      if (!(p_acc && isb(p_byte) && ch2code(p_byte) == o_data)) vld_bad++;
    end
    if (o_clr) begin
      ev_s = {ev_s, "|"};
      if (o_vld) overlap++;
    end
    if (!o_byte_rdy) rdy_low++;
    p_acc  = rst && i_byte_vld && o_byte_rdy;
    p_byte = i_byte;
  end

  task automatic do_reset();
    i_byte_vld = 0;
    i_byte = 0;
    #2 rst = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1;
    ev_s = "";
    rdy_low = 0;
  endtask

  task automatic send(byte b, bit gaps);
    int w;
    if (gaps && $urandom_range(0, 3) == 0) begin
      i_byte_vld = 0;
      i_byte = 8'($urandom);
      repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    end
    i_byte = b;
    i_byte_vld = 1;
    w = 0;
    forever begin
      @(negedge clk);
      if (o_byte_rdy) begin @(posedge clk); #1; break; end
      @(posedge clk); #1;
      w++;
      if (w > 20) begin
        nchk++; nerr++;
        $display("FAIL send_timeout: byte %0h not accepted, expected acceptance", b);
        break;
      end
    end
  endtask

  task automatic run_stream(bit gaps);
    foreach (stim[i]) send(stim[i], gaps);
    i_byte_vld = 0;
    repeat (6) begin @(posedge clk); #1; end
  endtask

  task automatic addv(string s, string q, int ql, bit qv, bit e, int c, string ev, int rl);
    vec_t v;
    v.stim = s; v.q = q; v.qlen = ql; v.qvld = qv; v.err = e; v.cnt = c; v.ev = ev; v.rdylow = rl;
    tbl.push_back(v);
  endtask

  initial begin
    string s55, q50;
    rst = 1; i_byte_vld = 0; i_byte = 0;
    s55 = ""; q50 = "";
    for (int i = 0; i < 11; i++) s55 = {s55, "ACGTA"};
    for (int i = 0; i < 10; i++) q50 = {q50, "ACGTA"};

    addv(">q\nACGT\n>d1\nTTGA\n", "ACGT", 3, 1, 0, 1, "TTGA|", 1);
    addv({">q\n", s55, "\n>d\nGA\n"}, q50, 49, 1, 1, 1, "GA|", 1);
    addv(">q\nA\n>d1\nAC\n\n>d2\nGT\n", "A", 0, 1, 0, 2, "AC|GT|", 2);
    addv(">q\nG\nAcNgT\r\n", "G", 0, 1, 1, 1, "ACGT|", 1);
    addv(">q\nT\n>a\nCC>b\nG\n", "T", 0, 1, 0, 2, "CC|G|", 2);
    addv("x\n>q\nCA\n", "CA", 1, 1, 1, 0, "", 0);
    addv(">q\n\nTT\n>d\nA\n", "TT", 1, 1, 0, 1, "A|", 1);

    do_reset();
    chk("reset_rdy", o_byte_rdy, 1);
    chk("reset_qvld", o_query_vld, 0);
    chk("reset_vld", o_vld, 0);
    chk("reset_cnt", o_seq_cnt, 0);
    chk("reset_err", o_err, 0);

    foreach (tbl[t]) begin
      do_reset();
      stim = {};
      push_str(tbl[t].stim);
      run_stream(0);
      chk($sformatf("t%0d_qvld", t), o_query_vld, tbl[t].qvld);
      chk($sformatf("t%0d_qlen", t), o_query_length, tbl[t].qlen);
      chk($sformatf("t%0d_query", t), o_query, qbits_of(tbl[t].q));
      chk($sformatf("t%0d_err", t), o_err, tbl[t].err);
      chk($sformatf("t%0d_cnt", t), o_seq_cnt, tbl[t].cnt);
      chk($sformatf("t%0d_rdylow", t), rdy_low, tbl[t].rdylow);
      chk_s($sformatf("t%0d_events", t), ev_s, tbl[t].ev);
    end

    do_reset();
    stim = {};
    push_str(">q\nA\n>d\nG");
    foreach (stim[i]) send(stim[i], 0);
    chk("mid_vld_before_rst", o_vld, 1);
    #2 rst = 0;
    #1;
    chk("async_vld", o_vld, 0);
    chk("async_data", o_data, 0);
    chk("async_qvld", o_query_vld, 0);
    chk("async_query", o_query, 0);
    chk("async_rdy", o_byte_rdy, 1);
    chk("async_clr", o_clr, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    ev_s = "";
    stim = {};
    push_str("AC\n");
    run_stream(0);
    chk("post_rst_qvld", o_query_vld, 0);
    chk("post_rst_err", o_err, 1);
    chk_s("post_rst_events", ev_s, "");

    for (int it = 0; it < 20; it++) begin
      int qn, nr, nb;
      stim = {};
      push_str(">q\n");
      qn = $urandom_range(1, 56);
      for (int k = 0; k < qn; k++) begin
        stim.push_back(code2ch(2'($urandom)));
        if ($urandom_range(0, 25) == 0) stim.push_back(8'h4E);
      end
      stim.push_back(8'h0A);
      nr = $urandom_range(1, 4);
      for (int r = 0; r < nr; r++) begin
        if ($urandom_range(0, 1) == 1) push_str(">d\n");
        if ($urandom_range(0, 4) == 0) stim.push_back(8'h0A);
        nb = $urandom_range(1, 8);
        for (int k = 0; k < nb; k++) begin
          byte c;
          c = code2ch(2'($urandom));
          if ($urandom_range(0, 1) == 1) c = c | 8'h20;
          stim.push_back(c);
          if ($urandom_range(0, 9) == 0) stim.push_back(8'h0D);
          if ($urandom_range(0, 15) == 0) stim.push_back(8'h78);
        end
        stim.push_back(8'h0A);
        if ($urandom_range(0, 3) == 0) stim.push_back(8'h0A);
      end
      model();
      do_reset();
      run_stream(1);
      chk_s($sformatf("r%0d_events", it), ev_s, m_ev);
      chk($sformatf("r%0d_qvld", it), o_query_vld, m_qvld);
      chk($sformatf("r%0d_qlen", it), o_query_length, m_qlen);
      chk($sformatf("r%0d_query", it), o_query, m_q);
      chk($sformatf("r%0d_err", it), o_err, m_err);
      chk($sformatf("r%0d_cnt", it), o_seq_cnt, m_cnt);
      chk($sformatf("r%0d_rdylow", it), rdy_low, m_cnt);
    end

    chk("vld_without_accepted_base", vld_bad, 0);
    chk("vld_clr_overlap", overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
